// File: rtl/div_pkg.sv
// Shared types and defaults for the repeated-subtraction divider.
// The optional DIV_FAST_EN build swaps the subtract loop for a shift-subtract loop.
package div_pkg;

  localparam int DIV_WIDTH_DEFAULT = 16;

  typedef enum logic [2:0] {
    IDLE,
    LDA,
    LDB,
    SUB,
    DONE
  } div_state_t;

endpackage

// File: rtl/div_repsub_datapath.sv
// R, D and Q registers with subtractor and compare, driven by controller strobes.
// With DIV_FAST_EN the loop becomes a WIDTH-step restoring shift-subtract.
module div_repsub_datapath
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_a,
  input  logic             load_b,
  input  logic             clear,
  input  logic             sub,
  input  logic             inc,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
`ifdef DIV_FAST_EN
  output logic             last,
`else
  output logic             ge,
`endif
  output logic             d_is_zero
);

  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;

  assign d_is_zero = (data_in == '0);
  assign quotient  = q;
  assign remainder = r;

`ifdef DIV_FAST_EN
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             step_ge;

  // Q doubles as the dividend shift register; its MSB feeds the partial remainder.
  assign shifted = {r, q[WIDTH-1]};
  assign trial   = shifted - {1'b0, d};
  assign step_ge = (shifted >= {1'b0, d});
  assign last    = (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r   <= '0;
      d   <= '0;
      q   <= '0;
      cnt <= '0;
    end else begin
      if (load_a) r <= data_in;
      if (load_b) begin
        d   <= data_in;
        cnt <= CNT_W'(WIDTH - 1);
      end
      if (clear) begin
        if (d_is_zero) begin
          q <= '1;
        end else begin
          q <= r;
          r <= '0;
        end
      end
      if (sub) r <= step_ge ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
      if (inc) begin
        q   <= {q[WIDTH-2:0], step_ge};
        cnt <= cnt - CNT_W'(1);
      end
    end
  end
`else
  assign ge = (r >= d);

  always_ff @(posedge clk) begin
    if (rst) begin
      r <= '0;
      d <= '0;
      q <= '0;
    end else begin
      if (load_a) r <= data_in;
      if (load_b) d <= data_in;
      if (clear)  q <= d_is_zero ? '1 : '0;
      if (sub)    r <= r - d;
      if (inc)    q <= q + WIDTH'(1);
    end
  end
`endif

endmodule

// File: rtl/div_repsub.sv
// Unsigned divider top: Moore controller around div_repsub_datapath.
// Define DIV_FAST_EN for the fixed-latency shift-subtract variant.
module div_repsub
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done,
  output logic             div_zero,
  output logic             busy
);

  div_state_t state_q;
  div_state_t state_d;
  logic       load_a;
  logic       load_b;
  logic       clear;
  logic       sub;
  logic       inc;
  logic       d_is_zero;
`ifdef DIV_FAST_EN
  logic       last;
`else
  logic       ge;
`endif

  div_repsub_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .load_a    (load_a),
    .load_b    (load_b),
    .clear     (clear),
    .sub       (sub),
    .inc       (inc),
    .quotient  (quotient),
    .remainder (remainder),
`ifdef DIV_FAST_EN
    .last      (last),
`else
    .ge        (ge),
`endif
    .d_is_zero (d_is_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      div_zero <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == LDB) div_zero <= d_is_zero;
    end
  end

  always_comb begin
    state_d = state_q;
    load_a  = 1'b0;
    load_b  = 1'b0;
    clear   = 1'b0;
    sub     = 1'b0;
    inc     = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = LDA;
      LDA: begin
        load_a  = 1'b1;
        state_d = LDB;
      end
      LDB: begin
        load_b  = 1'b1;
        clear   = 1'b1;
        state_d = d_is_zero ? DONE : SUB;
      end
      SUB: begin
`ifdef DIV_FAST_EN
        sub = 1'b1;
        inc = 1'b1;
        if (last) state_d = DONE;
`else
        // The final compare that fails costs one extra SUB cycle.
        if (ge) begin
          sub = 1'b1;
          inc = 1'b1;
        end else begin
          state_d = DONE;
        end
`endif
      end
      DONE: if (start) state_d = LDA;
      default: state_d = IDLE;
    endcase
  end

  assign done = (state_q == DONE);
  assign busy = (state_q == LDA) || (state_q == LDB) || (state_q == SUB);

endmodule

// File: tb/tb_div_repsub.sv
// Directed self-checking bench for div_repsub; expected values are hand-computed.
// Latency expectations follow the DIV_FAST_EN setting of the build.
module tb_div_repsub;

  localparam int WIDTH  = 16;
  localparam int BUDGET = 70000;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             done;
  logic             div_zero;
  logic             busy;

  int checks = 0;
  int errors = 0;
  int lat;
  bit busy_ok;

  div_repsub #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .data_in   (data_in),
    .quotient  (quotient),
    .remainder (remainder),
    .done      (done),
    .div_zero  (div_zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_lat(input int q);
`ifdef DIV_FAST_EN
    return 2 + WIDTH;
`else
    return 3 + q;
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Launches one division; returns n such that done rose after edge k+n.
  task automatic applyStimulus(input logic [WIDTH-1:0] dividend, input logic [WIDTH-1:0] divisor,
                               input int pulse_at, output int n, output bit busy_held);
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("launch_busy", 32'(busy), 32'd1);
    checkOutput("launch_done", 32'(done), 32'd0);
    data_in = dividend;
    tick();
    data_in = divisor;
    tick();
    data_in = '0;
    n = 2;
    busy_held = 1'b1;
    while (!done && n < BUDGET) begin
      if (!busy) busy_held = 1'b0;
      if (n == pulse_at) start = 1'b1;
      tick();
      start = 1'b0;
      n++;
    end
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_quot", 32'(quotient), 32'd0);
    checkOutput("reset_rem", 32'(remainder), 32'd0);
    checkOutput("reset_dz", 32'(div_zero), 32'd0);

    applyStimulus(16'd100, 16'd7, -1, lat, busy_ok);
    checkOutput("d100_7_lat", 32'(lat), 32'(exp_lat(14)));
    checkOutput("d100_7_quot", 32'(quotient), 32'd14);
    checkOutput("d100_7_rem", 32'(remainder), 32'd2);
    checkOutput("d100_7_dz", 32'(div_zero), 32'd0);

    applyStimulus(16'd5, 16'd9, -1, lat, busy_ok);
    checkOutput("d5_9_lat", 32'(lat), 32'(exp_lat(0)));
    checkOutput("d5_9_quot", 32'(quotient), 32'd0);
    checkOutput("d5_9_rem", 32'(remainder), 32'd5);

    applyStimulus(16'd1234, 16'd0, -1, lat, busy_ok);
    checkOutput("dz_lat", 32'(lat), 32'd2);
    checkOutput("dz_flag", 32'(div_zero), 32'd1);
    checkOutput("dz_quot", 32'(quotient), 32'hFFFF);
    checkOutput("dz_rem", 32'(remainder), 32'd1234);

    applyStimulus(16'hFFFF, 16'd1, -1, lat, busy_ok);
    checkOutput("max_lat", 32'(lat), 32'(exp_lat(65535)));
    checkOutput("max_quot", 32'(quotient), 32'hFFFF);
    checkOutput("max_rem", 32'(remainder), 32'd0);
    checkOutput("max_busy_held", 32'(busy_ok), 32'd1);
    checkOutput("max_dz", 32'(div_zero), 32'd0);

    // Abort an operation partway through the subtract loop.
    start = 1'b1;
    tick();
    start = 1'b0;
    data_in = 16'd100;
    tick();
    data_in = 16'd7;
    tick();
    data_in = '0;
    tick();
    tick();
    checkOutput("abort_in_sub", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_quot", 32'(quotient), 32'd0);
    checkOutput("abort_rem", 32'(remainder), 32'd0);

    applyStimulus(16'd20, 16'd4, -1, lat, busy_ok);
    checkOutput("d20_4_lat", 32'(lat), 32'(exp_lat(5)));
    checkOutput("d20_4_quot", 32'(quotient), 32'd5);
    checkOutput("d20_4_rem", 32'(remainder), 32'd0);

    applyStimulus(16'd100, 16'd7, 5, lat, busy_ok);
    checkOutput("ign_lat", 32'(lat), 32'(exp_lat(14)));
    checkOutput("ign_quot", 32'(quotient), 32'd14);
    checkOutput("ign_rem", 32'(remainder), 32'd2);

    // Relaunch straight from DONE.
    applyStimulus(16'd30, 16'd4, -1, lat, busy_ok);
    checkOutput("d30_4_lat", 32'(lat), 32'(exp_lat(7)));
    checkOutput("d30_4_quot", 32'(quotient), 32'd7);
    checkOutput("d30_4_rem", 32'(remainder), 32'd2);

    tick();
    tick();
    checkOutput("hold_done", 32'(done), 32'd1);
    checkOutput("hold_quot", 32'(quotient), 32'd7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_repsub.md
Name: div_repsub

Overview:
- Unsigned integer divider built from repeated subtraction.
- Inverse companion of the team's repeated-addition multiplier, with the same start/done handshake and single shared operand bus: dividend first, divisor next.
- Split into a datapath (R, D and Q registers, subtractor, compare) and a Moore controller.
- Sits beside the multiplier as a standalone arithmetic unit.

Parameters:
- WIDTH, 16, operand, quotient and remainder width in bits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE or DONE.
- data_in  input  WIDTH  shared operand bus: dividend in LDA cycle, divisor in LDB cycle.
- quotient  output  WIDTH  Q register.
- remainder  output  WIDTH  R register.
- done  output  1  high while in DONE.
- div_zero  output  1  divisor was 0; valid while done=1.
- busy  output  1  high in LDA, LDB, SUB.

Behaviour:
- Reset (rst=1 at an edge, any state, including mid-operation):
  - state<=IDLE.
  - R, D, Q <= 0.
  - done, div_zero, busy = 0.
- All outputs are registered or decoded from state only (Moore); no combinational path from inputs to outputs.
- States: IDLE, LDA, LDB, SUB, DONE.
- IDLE: start=1 -> LDA.
- LDA: R<=data_in; -> LDB. start is ignored here.
- LDB: D<=data_in; Q<=0; div_zero<=0.
  - data_in==0 -> DONE with div_zero<=1, Q<=all-ones, R unchanged (holds the dividend).
  - Else -> SUB.
- SUB, one compare per cycle:
  - R>=D -> R<=R-D, Q<=Q+1, stay in SUB.
  - Else -> DONE; R and Q hold.
- DONE: done=1; quotient and remainder hold.
  - start=1 -> LDA, and done drops in the next cycle.
  - Otherwise stay in DONE indefinitely.
- Latency: start sampled at edge k gives done=1 after edge k+3+Q, where Q is the quotient. Divide-by-zero gives done after edge k+2.
- Width rules:
  - Subtraction never underflows, because it is guarded by R>=D.
  - Q never exceeds the dividend, so Q+1 cannot wrap.
  - Worst case is dividend 2^WIDTH-1 with divisor 1: 2^WIDTH-1 subtract cycles.
- Dividend < divisor: one SUB cycle, then Q=0 and R=dividend.
- Dividend == 0: Q=0, R=0, done after edge k+3.
- A start arriving while busy=1 is ignored; there is no queueing.

Optional Feature:
- Macro: DIV_FAST_EN.
- Defined: SUB is replaced by a WIDTH-iteration restoring shift-subtract loop.
  - An iteration counter runs WIDTH-1 down to 0.
  - Each iteration: partial remainder <= {remainder, next dividend bit}; subtract the divisor if the result is >= divisor; shift the quotient bit in.
  - done follows edge k+2+WIDTH regardless of the operand values.
  - Results and div_zero behaviour are identical to the repeated-subtraction form.
- Undefined: repeated-subtraction loop exactly as above.

Decomposition:
- Package div_pkg:
  - State enum div_state_t (IDLE, LDA, LDB, SUB, DONE).
  - DIV_WIDTH_DEFAULT=16.
- Sub-module div_repsub_datapath:
  - Holds the R, D and Q registers, the subtractor and the R>=D comparator, plus the shift logic under DIV_FAST_EN.
  - Takes load, clear, sub and inc strobes from the controller; returns the ge and d_is_zero flags.
- The controller lives in div_repsub itself.

Test Plan:
- Reset, then start=1 at edge k, data_in=100 at LDA, 7 at LDB -> done=1 after edge k+17; quotient=14, remainder=2, div_zero=0. Under DIV_FAST_EN: done after edge k+18, same results.
- Dividend 5, divisor 9 -> quotient=0, remainder=5, done after edge k+3.
- Dividend 1234, divisor 0 -> done after edge k+2; div_zero=1, quotient=16'hFFFF, remainder=1234.
- Dividend 16'hFFFF, divisor 1 -> quotient=16'hFFFF, remainder=0, done after 65538 cycles; busy stays high throughout.
- rst=1 for one edge while in SUB -> next cycle shows state IDLE, quotient=0, remainder=0, done=0, busy=0. A following 20/4 operation returns quotient 5, remainder 0.
- start pulsed during SUB is ignored, and the result is unchanged. start pulsed in DONE launches a second operation (30/4): done drops, then quotient=7, remainder=2.
